// File: rtl/mlp_mac_ci.sv
// mlp_mac_ci: multi-cycle Nios II custom-instruction slave for MLP inference.
// Packed signed fixed-point multiply-accumulate into a small bank of
// accumulators, with bias preload and ReLU/saturating readout.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   clk_en   global hold; when low every register keeps its value
//   start    one-cycle instruction request, accepted only in IDLE
//   n        n[2:0] opcode, n[4:3] accumulator select, n[7:5] ignored
//   dataa    operand A, packed signed lanes (lane0 in the low bits)
//   datab    operand B, packed signed lanes
//   result   instruction result, valid with done, held until next accept
//   done     completion pulse (one enabled cycle)
//   busy     high from the cycle after accept through the done cycle
module mlp_mac_ci #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int FRAC_W = 6,
  parameter int N_ACC  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [7:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  localparam int LANES = 32 / DATA_W;
  localparam int TMP_W = ACC_W + 2;

  localparam logic [2:0] OP_CLEAR = 3'd0;
  localparam logic [2:0] OP_MAC   = 3'd1;
  localparam logic [2:0] OP_RELU  = 3'd2;
  localparam logic [2:0] OP_RAW   = 3'd3;
  localparam logic [2:0] OP_BIAS  = 3'd4;

  localparam logic [1:0] SEL_MASK = 2'(N_ACC - 1);
  localparam logic signed [63:0] ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
  localparam logic signed [63:0] ACC_MIN = -(64'sd1 <<< (ACC_W - 1));
  localparam logic signed [ACC_W-1:0] RELU_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);

  typedef enum logic [1:0] {IDLE, MAC, FIN} state_t;

  state_t state, state_nx;

  logic [2:0]              op_q;
  logic [1:0]              sel_q;
  logic [31:0]             a_q, b_q;
  logic [5:0]              k;
  logic signed [TMP_W-1:0] tmp;
  logic signed [ACC_W-1:0] acc [N_ACC];

  logic [1:0]              sel_in;
  logic signed [ACC_W-1:0] acc_in;
  logic signed [DATA_W-1:0] a_lane, b_lane;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [TMP_W-1:0] tmp_sum;
  logic signed [63:0]      mac_sum;
  logic signed [ACC_W-1:0] mac_sat;
  logic signed [63:0]      bias_v;
  logic signed [ACC_W-1:0] shifted;
  logic [31:0]             relu_res;
  logic [31:0]             single_res;
  logic                    last_lane;
  logic                    unused_ok;

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [63:0] v);
    if (v > ACC_MAX)      return ACC_W'(ACC_MAX);
    else if (v < ACC_MIN) return ACC_W'(ACC_MIN);
    else                  return ACC_W'(v);
  endfunction

  assign unused_ok = ^n[7:5];
  assign sel_in    = n[4:3] & SEL_MASK;
  assign acc_in    = acc[sel_in];
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign last_lane = (k == 6'(LANES - 1));

  // Lane datapath: the final lane's product is folded straight into the
  // saturated sum so result is ready when FIN (the done cycle) begins.
  always_comb begin
    a_lane  = signed'(a_q[int'(k) * DATA_W +: DATA_W]);
    b_lane  = signed'(b_q[int'(k) * DATA_W +: DATA_W]);
    prod    = a_lane * b_lane;
    tmp_sum = tmp + TMP_W'(prod);
    mac_sum = 64'(acc[sel_q]) + 64'(tmp_sum);
    mac_sat = sat_acc(mac_sum);
  end

  // Single-cycle opcodes are evaluated directly from the request inputs.
  always_comb begin
    bias_v  = 64'(signed'(dataa)) <<< FRAC_W;
    shifted = acc_in >>> FRAC_W;
    if (shifted < 0)             relu_res = '0;
    else if (shifted > RELU_MAX) relu_res = 32'($unsigned(RELU_MAX));
    else                         relu_res = 32'($unsigned(shifted));
    case (n[2:0])
      OP_RELU: single_res = relu_res;
      OP_RAW:  single_res = 32'(acc_in);
      OP_BIAS: single_res = 32'(sat_acc(bias_v));
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (n[2:0] == OP_MAC) ? MAC : FIN;
      MAC:     if (last_lane) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Accumulator writes all happen in FIN, taking the new value from result
  // (CLEAR, MAC and BIAS each leave the new accumulator value there).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      op_q   <= '0;
      sel_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      k      <= '0;
      tmp    <= '0;
      result <= '0;
      for (int unsigned i = 0; i < N_ACC; i++) acc[i] <= '0;
    end else if (clk_en) begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          op_q  <= n[2:0];
          sel_q <= sel_in;
          a_q   <= dataa;
          b_q   <= datab;
          k     <= '0;
          tmp   <= '0;
          if (n[2:0] != OP_MAC) result <= single_res;
        end
        MAC: begin
          tmp <= tmp_sum;
          k   <= k + 6'd1;
          if (last_lane) result <= 32'(mac_sat);
        end
        FIN: begin
          if (op_q == OP_CLEAR || op_q == OP_MAC || op_q == OP_BIAS)
            acc[sel_q] <= result[ACC_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
